maze_walker: RTL and testbench

- Right-hand wall-follower controller that drives the 64x64 maze cell memory.
- Sits directly upstream of the maze storage. It issues oe reads and we visited-marks at row/col, and consumes the registered 1-cycle-latency cell bit (1 = wall, 0 = free).
- Walks from the start cell until it reaches a border cell other than the start, then reports done/success.

---
 rtl/maze_walker_pkg.sv | 10 +
 rtl/maze_walker_nbr.sv | 23 ++
 rtl/maze_walker.sv | 136 +++++++++++++
 tb/tb_maze_walker.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/maze_walker_pkg.sv
// maze_walker_pkg: shared types and constants for the maze wall follower.
package maze_walker_pkg;
    localparam int MAZE_DIM = 64;
    localparam int COORD_W = 6;
    typedef enum logic [1:0] {N = 2'd0, E = 2'd1, S = 2'd2, W = 2'd3} dir_t;
    typedef enum logic [2:0] {IDLE, MARK, PROBE, DECIDE, MOVED, FAIL, DONE} state_t;
    // Row/col deltas indexed by dir_t
    localparam logic signed [1:0] ROW_OFF [4] = '{-2'sd1, 2'sd0, 2'sd1, 2'sd0};
    localparam logic signed [1:0] COL_OFF [4] = '{2'sd0, 2'sd1, 2'sd0, -2'sd1};
endpackage

// File: rtl/maze_walker_nbr.sv
// maze_walker_nbr: candidate neighbour for probe k (0 right, 1 forward, 2 left, 3 back).
module maze_walker_nbr
    import maze_walker_pkg::*;
(
    input  logic [COORD_W-1:0] cur_row,
    input  logic [COORD_W-1:0] cur_col,
    input  dir_t               heading,
    input  logic [1:0]         k,
    output logic [COORD_W-1:0] cand_row,
    output logic [COORD_W-1:0] cand_col,
    output dir_t               d,
    output logic               out_of_range
);
    logic signed [COORD_W+1:0] r, c;
    always_comb begin
        d = dir_t'(heading + 2'd1 - k);
        r = $signed({2'b00, cur_row}) + ROW_OFF[d];
        c = $signed({2'b00, cur_col}) + COL_OFF[d];
        out_of_range = r < 0 || c < 0 || r >= MAZE_DIM || c >= MAZE_DIM;
        cand_row = r[COORD_W-1:0];
        cand_col = c[COORD_W-1:0];
    end
endmodule

// File: rtl/maze_walker.sv
// maze_walker: right-hand wall follower driving a 64x64 cell memory.
// Defining MAZE_WALKER_TIMEOUT_EN adds the MAX_STEPS parameter and ends looping walks at that count.
module maze_walker
    import maze_walker_pkg::*;
#(
    parameter logic [1:0] INIT_DIR = 2'd1,
    parameter int         STEP_W   = 16
`ifdef MAZE_WALKER_TIMEOUT_EN
    ,
    parameter logic [STEP_W-1:0] MAX_STEPS = 16'd8192
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COORD_W-1:0] starting_row,
    input  logic [COORD_W-1:0] starting_col,
    input  logic               maze_in,
    output logic [COORD_W-1:0] row,
    output logic [COORD_W-1:0] col,
    output logic               maze_oe,
    output logic               maze_we,
    output logic               busy,
    output logic               done,
    output logic               success,
    output logic [STEP_W-1:0]  steps
);
    state_t state, nxt_state;
    dir_t heading, nxt_heading, d, cand_dir;
    logic [1:0] k, nxt_k;
    logic [COORD_W-1:0] cur_row, cur_col, nxt_cur_row, nxt_cur_col, st_row, st_col, cand_row, cand_col;
    logic oor, at_exit, timeout, probe_hit, mark_nxt;

    assign at_exit = (cur_row == '0 || &cur_row || cur_col == '0 || &cur_col) &&
                     {cur_row, cur_col} != {st_row, st_col};
`ifdef MAZE_WALKER_TIMEOUT_EN
    assign timeout = steps == MAX_STEPS;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        nxt_state = state;
        nxt_heading = heading;
        nxt_k = k;
        nxt_cur_row = cur_row;
        nxt_cur_col = cur_col;
        case (state)
            IDLE, DONE: if (start) begin
                nxt_state = MARK;
                nxt_heading = dir_t'(INIT_DIR);
                nxt_cur_row = starting_row;
                nxt_cur_col = starting_col;
            end
            MARK: begin
                nxt_state = PROBE;
                nxt_k = '0;
            end
            // A PROBE cycle without a read means the candidate was off the grid
            PROBE: begin
                nxt_state = maze_oe ? DECIDE : (&k ? FAIL : PROBE);
                nxt_k = maze_oe ? k : k + 2'd1;
            end
            DECIDE: if (!maze_in) begin
                nxt_state = MOVED;
                nxt_cur_row = row;
                nxt_cur_col = col;
                nxt_heading = cand_dir;
            end else begin
                nxt_state = &k ? FAIL : PROBE;
                nxt_k = k + 2'd1;
            end
            MOVED: begin
                nxt_state = (at_exit || timeout) ? DONE : PROBE;
                nxt_k = '0;
            end
            FAIL: nxt_state = DONE;
            default: ;
        endcase
    end

    // Strobes are registered, so the neighbour is evaluated for the upcoming state
    maze_walker_nbr u_nbr (
        .cur_row(nxt_cur_row), .cur_col(nxt_cur_col), .heading(nxt_heading), .k(nxt_k),
        .cand_row(cand_row), .cand_col(cand_col), .d(d), .out_of_range(oor)
    );

    assign probe_hit = nxt_state == PROBE && !oor;
    assign mark_nxt = nxt_state == MARK || nxt_state == MOVED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            heading <= dir_t'(INIT_DIR);
            cand_dir <= N;
            k <= '0;
            cur_row <= '0;
            cur_col <= '0;
            st_row <= '0;
            st_col <= '0;
            row <= '0;
            col <= '0;
            maze_oe <= 1'b0;
            maze_we <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            success <= 1'b0;
            steps <= '0;
        end else begin
            state <= nxt_state;
            heading <= nxt_heading;
            k <= nxt_k;
            cur_row <= nxt_cur_row;
            cur_col <= nxt_cur_col;
            maze_oe <= probe_hit;
            maze_we <= mark_nxt;
            row <= probe_hit ? cand_row : mark_nxt ? nxt_cur_row : row;
            col <= probe_hit ? cand_col : mark_nxt ? nxt_cur_col : col;
            if (probe_hit) cand_dir <= d;
            if ((state == IDLE || state == DONE) && start) begin
                st_row <= starting_row;
                st_col <= starting_col;
                busy <= 1'b1;
                done <= 1'b0;
                success <= 1'b0;
                steps <= '0;
            end
            if (state == DECIDE && !maze_in && !(&steps)) steps <= steps + 1'b1;
            if (nxt_state == DONE && state != DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
                success <= state == MOVED && at_exit;
            end
        end
    end
endmodule

// File: tb/tb_maze_walker.sv
// tb_maze_walker: directed walks over a behavioural maze memory with a result scoreboard.
module tb_maze_walker;
    logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, maze_in = 1'b0;
    logic [5:0] starting_row = '0, starting_col = '0, row, col;
    logic maze_oe, maze_we, busy, done, success;
    logic [15:0] steps;
    logic wall [64][64];
    typedef struct { logic succ; int n; int r; int c; } res_t;
    res_t exp_q[$];
    int oe_q[$];
    int n_chk = 0, n_pass = 0, oe_cnt = 0, we_cnt = 0;

    maze_walker #(
        .INIT_DIR(2'd1), .STEP_W(16)
`ifdef MAZE_WALKER_TIMEOUT_EN
        , .MAX_STEPS(16'd4)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .starting_row(starting_row), .starting_col(starting_col),
        .maze_in(maze_in), .row(row), .col(col), .maze_oe(maze_oe), .maze_we(maze_we),
        .busy(busy), .done(done), .success(success), .steps(steps)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (maze_oe) maze_in <= wall[row][col];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (maze_oe) begin
            oe_cnt++;
            check("oe_we_excl", {31'd0, maze_we}, 32'd0);
            if (oe_q.size() != 0) check("oe_addr", {20'd0, row, col}, oe_q.pop_front());
        end
        if (maze_we) we_cnt++;
    end

    task automatic fill_walls();
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 64; j++)
                wall[i][j] = 1'b1;
    endtask

    task automatic walk(input string tag, input int r, input int c, input logic s, input int n,
                        input int er, input int ec, input bit poke);
        res_t e;
        int cyc = 0;
        int we0 = we_cnt;
        exp_q.push_back('{s, n, er, ec});
        @(negedge clk);
        starting_row = 6'(r);
        starting_col = 6'(c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_mark"}, {19'd0, maze_we, row, col}, {19'd0, 1'b1, 6'(r), 6'(c)});
        check({tag, "_busy"}, {30'd0, busy, done}, 32'd2);
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (poke) begin
                start = cyc == 20;
                starting_row = 6'd40;
                starting_col = 6'd40;
            end
        end
        e = exp_q.pop_front();
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_success"}, {31'd0, success}, {31'd0, e.succ});
        check({tag, "_steps"}, {16'd0, steps}, e.n);
        check({tag, "_pos"}, {20'd0, row, col}, e.r * 64 + e.c);
        check({tag, "_marks"}, we_cnt - we0, e.n + 1);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int base;
        int cyc;
        fill_walls();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_strobes", {29'd0, maze_oe, maze_we, busy}, 32'd0);
        check("rst_status", {30'd0, done, success}, 32'd0);
        check("rst_addr_steps", {4'd0, row, col, steps}, 32'd0);
        rst_n = 1'b1;

        for (int j = 0; j < 64; j++) wall[10][j] = 1'b0;
        walk("corridor", 10, 0, 1'b1, 63, 10, 63, 1'b1);

        fill_walls();
        for (int i = 6; i < 64; i++) wall[i][5] = 1'b0;
        oe_q.push_back(6 * 64 + 5);
        walk("turn", 5, 5, 1'b1, 58, 63, 5, 1'b0);

        fill_walls();
        base = oe_cnt;
        oe_q.push_back(31 * 64 + 30);
        oe_q.push_back(30 * 64 + 31);
        oe_q.push_back(29 * 64 + 30);
        oe_q.push_back(30 * 64 + 29);
        walk("enclosed", 30, 30, 1'b0, 0, 30, 29, 1'b0);
        check("enclosed_oe_cnt", oe_cnt - base, 32'd4);
        check("enclosed_oe_left", oe_q.size(), 32'd0);

        base = oe_cnt;
        oe_q.push_back(1 * 64 + 63);
        oe_q.push_back(0 * 64 + 62);
        walk("corner", 0, 63, 1'b0, 0, 0, 62, 1'b0);
        check("corner_oe_cnt", oe_cnt - base, 32'd2);
        check("corner_oe_left", oe_q.size(), 32'd0);

        for (int j = 0; j < 64; j++) wall[10][j] = 1'b0;
        @(negedge clk);
        starting_row = 6'd10;
        starting_col = 6'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        cyc = 0;
        while (!maze_oe && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("midrst_pre_oe", {31'd0, maze_oe}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_strobes", {29'd0, maze_oe, maze_we, busy}, 32'd0);
        check("midrst_addr_steps", {4'd0, row, col, steps}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        walk("restart", 10, 0, 1'b1, 63, 10, 63, 1'b0);

`ifdef MAZE_WALKER_TIMEOUT_EN
        fill_walls();
        wall[20][20] = 1'b0;
        wall[20][21] = 1'b0;
        wall[21][20] = 1'b0;
        wall[21][21] = 1'b0;
        walk("timeout", 20, 20, 1'b0, 4, 20, 20, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
